fadd_share_arbiter: RTL and testbench

- Shares one instance of the team's pipelined single-precision floating-point adder between N_REQ requesters.
- Each cycle, a round-robin arbiter accepts at most one operand pair and registers it onto the adder inputs.
- A valid/tag shift register tracks the pair through the adder's fixed latency and routes the registered sum back to the originating requester as a one-cycle pulse.
- Sits between client blocks and the adder; the adder itself is instantiated outside this block.

---
 rtl/fadd_share_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fadd_share_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_share_arbiter.sv
// rtl/fadd_share_arbiter.sv - round-robin sharing of one pipelined FP adder among N_REQ requesters
//
// Purpose: accepts at most one operand pair per cycle from N_REQ clients and
// registers it onto an external fixed-latency adder. A valid/tag pipe follows
// each pair through the adder and returns the sum to its owner as a one-cycle pulse.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   en_mask         per-requester enable; a 0 bit blocks new grants
//   req_valid       requester i presents a pair on slice i of req_a/req_b
//   req_ready       one-hot grant, combinational
//   req_a, req_b    packed operands, slice i = [i*W +: W]
//   fa_a, fa_b      registered operands to the adder
//   fa_ans          adder result, LAT edges after fa_a/fa_b
//   rsp_valid       one-hot response pulse marking the owner
//   rsp_data        registered sum, meaningful while rsp_valid != 0
//   in_flight       pairs accepted but not yet responded
//   idle            nothing in flight and no enabled request pending

module fadd_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          en_mask,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*W-1:0]        req_a,
    input  logic [N_REQ*W-1:0]        req_b,
    output logic [W-1:0]              fa_a,
    output logic [W-1:0]              fa_b,
    input  logic [W-1:0]              fa_ans,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [W-1:0]              rsp_data,
    output logic [$clog2(LAT+3)-1:0]  in_flight,
    output logic                      idle
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int IF_W  = $clog2(LAT+3);

    // registered state
    logic [PTR_W-1:0]           rr_ptr_q,    rr_ptr_d;
    logic [W-1:0]               fa_a_q,      fa_a_d;
    logic [W-1:0]               fa_b_q,      fa_b_d;
    logic [LAT:0]               tag_vld_q,   tag_vld_d;
    logic [LAT:0][PTR_W-1:0]    tag_id_q,    tag_id_d;
    logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]               rsp_data_q,  rsp_data_d;
    logic [IF_W-1:0]            in_flight_q, in_flight_d;

    // arbitration results
    logic                       grant_found;
    logic [PTR_W-1:0]           grant_idx;
    logic [PTR_W:0]             scan_sum;
    logic [PTR_W-1:0]           scan_idx;
    logic [W-1:0]               a_sel;
    logic [W-1:0]               b_sel;
    logic                       rsp_fire;

    // Round-robin scan starting at rr_ptr; the extra bit in scan_sum lets the
    // wrap be done by one conditional subtract, which also covers non-power-of-two N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_found && req_valid[scan_idx] && en_mask[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Ready is the grant itself, so a grant is always a transfer.
    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Operand mux for the granted slice.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    assign rsp_fire = |rsp_valid_q;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        fa_a_d      = '0;
        fa_b_d      = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        in_flight_d = in_flight_q;

        if (grant_found) begin
            fa_a_d = a_sel;
            fa_b_d = b_sel;
            if (grant_idx == PTR_W'(N_REQ-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + PTR_W'(1);
            end
        end

        // Tag pipe shifts unconditionally: neither the adder nor the
        // response side can stall, so position encodes age exactly.
        tag_vld_d = {tag_vld_q[LAT-1:0], grant_found};
        tag_id_d  = {tag_id_q[LAT-1:0], grant_idx};

        // Final stage lines up with fa_ans carrying that pair's sum.
        if (tag_vld_q[LAT]) begin
            rsp_valid_d[tag_id_q[LAT]] = 1'b1;
            rsp_data_d                 = fa_ans;
        end

        // A pair stays counted through its response cycle.
        case ({grant_found, rsp_fire})
            2'b10:   in_flight_d = in_flight_q + IF_W'(1);
            2'b01:   in_flight_d = in_flight_q - IF_W'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            fa_a_q      <= '0;
            fa_b_q      <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            in_flight_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            fa_a_q      <= fa_a_d;
            fa_b_q      <= fa_b_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign fa_a      = fa_a_q;
    assign fa_b      = fa_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign in_flight = in_flight_q;
    assign idle      = (in_flight_q == '0) && ((req_valid & en_mask) == '0);

endmodule

// File: tb/tb_fadd_share_arbiter.sv
// tb/tb_fadd_share_arbiter.sv - self-checking bench for fadd_share_arbiter

module tb_fadd_share_arbiter;

    localparam int N_REQ = 4;
    localparam int LAT   = 3;
    localparam int W     = 32;

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     en_mask;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*W-1:0]   req_a;
    logic [N_REQ*W-1:0]   req_b;
    logic [W-1:0]         fa_a;
    logic [W-1:0]         fa_b;
    logic [W-1:0]         fa_ans;
    logic [N_REQ-1:0]     rsp_valid;
    logic [W-1:0]         rsp_data;
    logic [2:0]           in_flight;
    logic                 idle;

    int checks   = 0;
    int failures = 0;

    fadd_share_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_mask   (en_mask),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_ans    (fa_ans),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .in_flight (in_flight),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external adder: known vectors give real IEEE sums,
    // anything else a deterministic scramble so routing errors still show.
    function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h411C0000, 32'h3F100000}: fp_sum = 32'h41250000;
            {32'h41480000, 32'hC0B20000}: fp_sum = 32'h40DE0000;
            {32'hC0600000, 32'hC1080000}: fp_sum = 32'hC1400000;
            {32'h3F800000, 32'h40000000}: fp_sum = 32'h40400000;
            {32'h40A00000, 32'h40A00000}: fp_sum = 32'h41200000;
            {32'h3FE00000, 32'h41080000}: fp_sum = 32'h41240000;
            default:                      fp_sum = a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    logic [31:0] add_pipe [LAT];
    initial for (int k = 0; k < LAT; k++) add_pipe[k] = 32'h0;
    always @(posedge clk) begin
        for (int k = LAT-1; k > 0; k--) add_pipe[k] <= add_pipe[k-1];
        add_pipe[0] <= fp_sum(fa_a, fa_b);
    end
    assign fa_ans = add_pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct {
        int          due;
        int          owner;
        logic [31:0] sum;
    } rsp_t;

    rsp_t        mq[$];
    int          m_ptr = 0;
    int          m_cyc = 0;
    int          m_g;
    int          m_j;
    logic [31:0] m_fa_a = 0;
    logic [31:0] m_fa_b = 0;
    logic [31:0] m_last = 0;
    logic [3:0]  m_ready;
    rsp_t        m_item;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_fa_a", 64'(fa_a), 64'd0);
            chk("rst_fa_b", 64'(fa_b), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_data", 64'(rsp_data), 64'd0);
            chk("rst_in_flight", 64'(in_flight), 64'd0);
            mq.delete();
            m_ptr  = 0;
            m_cyc  = 0;
            m_fa_a = 0;
            m_fa_b = 0;
            m_last = 0;
        end else begin
            m_g = -1;
            for (int k = 0; k < N_REQ; k++) begin
                m_j = (m_ptr + k) % N_REQ;
                if (m_g < 0 && req_valid[m_j] && en_mask[m_j]) m_g = m_j;
            end
            m_ready = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
            chk("req_ready", 64'(req_ready), 64'(m_ready));
            chk("fa_a", 64'(fa_a), 64'(m_fa_a));
            chk("fa_b", 64'(fa_b), 64'(m_fa_b));
            chk("in_flight", 64'(in_flight), 64'(mq.size()));
            chk("idle", 64'(idle), 64'((mq.size() == 0) && ((req_valid & en_mask) == 0)));
            if (mq.size() > 0 && mq[0].due == m_cyc) begin
                m_item = mq.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1 << m_item.owner));
                chk("rsp_data", 64'(rsp_data), 64'(m_item.sum));
                m_last = m_item.sum;
            end else begin
                chk("rsp_valid_quiet", 64'(rsp_valid), 64'd0);
                chk("rsp_data_hold", 64'(rsp_data), 64'(m_last));
            end
            if (m_g >= 0) begin
                m_item.due   = m_cyc + LAT + 2;
                m_item.owner = m_g;
                m_item.sum   = fp_sum(req_a[m_g*W +: W], req_b[m_g*W +: W]);
                mq.push_back(m_item);
                m_fa_a = req_a[m_g*W +: W];
                m_fa_b = req_b[m_g*W +: W];
                m_ptr  = (m_g + 1) % N_REQ;
            end else begin
                m_fa_a = 0;
                m_fa_b = 0;
            end
            m_cyc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_pair(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic load_defaults();
        set_pair(0, 32'h41480000, 32'hC0B20000);
        set_pair(1, 32'hC0600000, 32'hC1080000);
        set_pair(2, 32'h3F800000, 32'h40000000);
        set_pair(3, 32'h40A00000, 32'h40A00000);
    endtask

    // Leaves the bench in the first cycle after release, DUT still in reset state.
    task automatic do_reset();
        tick();
        rst_n     = 1'b0;
        req_valid = '0;
        en_mask   = '1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        en_mask   = '1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // 1: single request from requester 0
        do_reset();
        set_pair(0, 32'h411C0000, 32'h3F100000);
        req_valid = 4'b0001;
        sample();
        chk("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0000;
        sample();
        chk("t1_in_flight_1", 64'(in_flight), 64'd1);
        for (int k = 0; k < LAT; k++) tick();
        tick();
        sample();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_data", 64'(rsp_data), 64'h41250000);
        tick();
        sample();
        chk("t1_in_flight_0", 64'(in_flight), 64'd0);
        chk("t1_idle", 64'(idle), 64'd1);
        chk("t1_rsp_hold", 64'(rsp_data), 64'h41250000);

        // 2: all four requesters continuously valid
        do_reset();
        load_defaults();
        req_valid = 4'b1111;
        sample();
        chk("t2_ready_0", 64'(req_ready), 64'h1);
        for (int k = 1; k < 10; k++) begin
            tick();
            sample();
            chk("t2_ready_rr", 64'(req_ready), 64'(1 << (k % N_REQ)));
            if (k == LAT + 2) begin
                chk("t2_rsp0_valid", 64'(rsp_valid), 64'h1);
                chk("t2_rsp0_data", 64'(rsp_data), 64'h40DE0000);
            end
            if (k == LAT + 3) begin
                chk("t2_rsp1_valid", 64'(rsp_valid), 64'h2);
                chk("t2_rsp1_data", 64'(rsp_data), 64'hC1400000);
            end
            if (k == LAT + 2) chk("t2_in_flight_max", 64'(in_flight), 64'(LAT + 2));
        end
        tick();
        req_valid = '0;
        for (int k = 0; k < LAT + 4; k++) tick();

        // 3: fairness, requester 1 asserts after the pointer passed it
        do_reset();
        load_defaults();
        req_valid = 4'b0100;
        sample();
        chk("t3_ready_r2", 64'(req_ready), 64'h4);
        tick();
        req_valid = 4'b0110;
        sample();
        chk("t3_ready_r1", 64'(req_ready), 64'h2);
        tick();
        sample();
        chk("t3_ready_r2_again", 64'(req_ready), 64'h4);
        tick();
        sample();
        chk("t3_ready_r1_again", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        for (int k = 0; k < LAT + 4; k++) tick();

        // 4: masking requester 2, then masking 0 after its grant
        do_reset();
        load_defaults();
        set_pair(0, 32'h3FE00000, 32'h41080000);
        en_mask   = 4'b1011;
        req_valid = 4'b1111;
        sample();
        chk("t4_ready_r0", 64'(req_ready), 64'h1);
        tick();
        en_mask = 4'b1010;
        sample();
        chk("t4_ready_r1", 64'(req_ready), 64'h2);
        for (int k = 2; k <= LAT + 2; k++) begin
            tick();
            sample();
            chk("t4_r2_blocked", 64'(req_ready[2]), 64'd0);
        end
        chk("t4_rsp0_valid", 64'(rsp_valid), 64'h1);
        chk("t4_rsp0_data", 64'(rsp_data), 64'h41240000);
        tick();
        req_valid = '0;
        en_mask   = '1;
        for (int k = 0; k < LAT + 4; k++) tick();

        // 5: reset with pairs inside the adder
        do_reset();
        load_defaults();
        req_valid = 4'b0111;
        tick();
        tick();
        tick();
        req_valid = '0;
        rst_n     = 1'b0;
        sample();
        chk("t5_in_flight_rst", 64'(in_flight), 64'd0);
        chk("t5_fa_a_rst", 64'(fa_a), 64'd0);
        chk("t5_rsp_valid_rst", 64'(rsp_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            sample();
            chk("t5_no_stale_rsp", 64'(rsp_valid), 64'd0);
        end
        tick();
        req_valid = 4'b1111;
        sample();
        chk("t5_first_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        for (int k = 0; k < LAT + 4; k++) tick();

        // 6: gaps between grants
        do_reset();
        load_defaults();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        sample();
        chk("t6_fa_a_issued", 64'(fa_a), 64'h41480000);
        tick();
        sample();
        chk("t6_fa_a_idle", 64'(fa_a), 64'd0);
        chk("t6_fa_b_idle", 64'(fa_b), 64'd0);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        sample();
        chk("t6_fa_a_idle2", 64'(fa_a), 64'd0);
        for (int k = 0; k < LAT + 4; k++) tick();
        sample();
        chk("t6_in_flight_0", 64'(in_flight), 64'd0);
        chk("t6_idle", 64'(idle), 64'd1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
